// File: rtl/invader_formation.sv
// Row of N_INV invaders that marches side to side, drops at the live edges,
// takes projectile hits, keeps a saturating score and reports clear/landing.
module invader_formation #(
    parameter int N_INV       = 5,
    parameter int SPACING     = 40,
    parameter int HALF_W      = 10,
    parameter int HEIGHT      = 20,
    parameter int PROJ_HALF   = 5,
    parameter int X_MIN       = 96,
    parameter int X_MAX       = 389,
    parameter int X_START     = 100,
    parameter int Y_START     = 10,
    parameter int DROP        = 5,
    parameter int Y_LIMIT     = 400,
    parameter int POINTS      = 50,
    parameter int BASE_PERIOD = 2
) (
    input  logic             dclk,
    input  logic             clr,
    input  logic             tick,
    input  logic             play,
    input  logic             proj_valid,
    input  logic [9:0]       proj_x,
    input  logic [9:0]       proj_y,
    output logic [9:0]       enemy_x,
    output logic [9:0]       enemy_y,
    output logic [N_INV-1:0] alive,
    output logic             hit_pulse,
    output logic [3:0]       hit_idx,
    output logic             proj_consume,
    output logic [13:0]      score,
    output logic             cleared,
    output logic             landed,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MARCH   = 2'd1,
        S_CLEARED = 2'd2,
        S_LANDED  = 2'd3
    } state_t;

    localparam int PERIOD_LO = (BASE_PERIOD / 2 > 1) ? BASE_PERIOD / 2 : 1;
    localparam int DIV_W     = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
    localparam int CNT_W     = $clog2(N_INV + 1);

    localparam logic [DIV_W-1:0]  DIV_TOP_HI   = DIV_W'(BASE_PERIOD - 1);
    localparam logic [DIV_W-1:0]  DIV_TOP_LO   = DIV_W'(PERIOD_LO - 1);
    localparam logic [CNT_W-1:0]  HALF_CNT     = CNT_W'(N_INV / 2);
    localparam logic [N_INV-1:0]  ALL_ALIVE    = {N_INV{1'b1}};
    localparam logic [N_INV-1:0]  ONE_BIT      = N_INV'(1);
    localparam logic [13:0]       SCORE_MAX    = 14'd9999;
    localparam logic [13:0]       SCORE_SAT_AT = 14'(9999 - POINTS);
    localparam logic signed [11:0] REACH       = 12'(HALF_W + PROJ_HALF);

    state_t             state_reg, state_next;
    logic [9:0]         x_reg, x_next;
    logic [9:0]         y_reg, y_next;
    logic [N_INV-1:0]   alive_reg, alive_next;
    logic               dir_reg, dir_next;      // 1 = moving right
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [13:0]        score_reg, score_next;
    logic               hit_pulse_reg, hit_pulse_next;
    logic [3:0]         hit_idx_reg, hit_idx_next;

    logic [11:0]        x12, y12;
    logic [N_INV-1:0]   col_hit;
    logic [3:0]         lo, hi, kill_idx;
    logic [CNT_W-1:0]   pop;
    logic               kill_any;
    logic [DIV_W-1:0]   div_top;
    logic               right_ok, left_ok;
    logic               step, drop, land_now;

    assign x12 = {2'b00, x_reg};
    assign y12 = {2'b00, y_reg};

    // Per-column overlap test against the registered (pre-step) position.
    generate
        for (genvar gi = 0; gi < N_INV; gi++) begin : g_col
            localparam logic [11:0] COL_OFF = 12'(gi * SPACING);
            logic [11:0]        col_cx;
            logic signed [11:0] dx;
            logic [11:0]        dy;
            assign col_cx = x12 + COL_OFF;
            assign dx     = $signed({2'b00, proj_x}) - $signed(col_cx);
            assign dy     = {2'b00, proj_y} - y12;
            assign col_hit[gi] = proj_valid && alive_reg[gi] && (proj_y > y_reg) &&
                                 (dy < 12'(HEIGHT)) && (dx < REACH) && (dx > -REACH);
        end
    endgenerate

    // Lowest live / highest live column, live count, lowest hit column.
    always_comb begin
        lo       = '0;
        hi       = '0;
        pop      = '0;
        kill_any = 1'b0;
        kill_idx = '0;
        for (int i = N_INV - 1; i >= 0; i--) begin
            if (alive_reg[i]) lo = 4'(i);
            if (col_hit[i]) begin
                kill_any = 1'b1;
                kill_idx = 4'(i);
            end
        end
        for (int i = 0; i < N_INV; i++) begin
            if (alive_reg[i]) hi = 4'(i);
            pop = pop + CNT_W'(alive_reg[i]);
        end
    end

    assign div_top  = (pop > HALF_CNT) ? DIV_TOP_HI : DIV_TOP_LO;
    assign right_ok = (x12 + 12'(hi) * 12'(SPACING) + 12'(HALF_W + 1)) <= 12'(X_MAX);
    // Left bound rearranged so the sum never goes below zero.
    assign left_ok  = (x12 + 12'(lo) * 12'(SPACING)) >= 12'(X_MIN + HALF_W + 1);

    always_comb begin
        x_next         = x_reg;
        y_next         = y_reg;
        dir_next       = dir_reg;
        alive_next     = alive_reg;
        div_next       = div_reg;
        score_next     = score_reg;
        hit_pulse_next = 1'b0;
        hit_idx_next   = hit_idx_reg;
        step           = 1'b0;
        drop           = 1'b0;
        land_now       = 1'b0;
        if (!play) begin
            x_next     = 10'(X_START);
            y_next     = 10'(Y_START);
            dir_next   = 1'b1;
            alive_next = ALL_ALIVE;
            div_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    score_next = '0;
                    alive_next = ALL_ALIVE;
                end
                S_MARCH: begin
                    if (tick) begin
                        if (div_reg >= div_top) begin
                            div_next = '0;
                            step     = 1'b1;
                        end else begin
                            div_next = div_reg + DIV_W'(1);
                        end
                    end
                    if (step) begin
                        if (dir_reg) begin
                            if (right_ok) x_next = x_reg + 10'd1;
                            else          drop   = 1'b1;
                        end else begin
                            if (left_ok)  x_next = x_reg - 10'd1;
                            else          drop   = 1'b1;
                        end
                    end
                    if (drop) begin
                        y_next   = y_reg + 10'(DROP);
                        dir_next = ~dir_reg;
                        land_now = (y12 + 12'(DROP) + 12'(HEIGHT)) >= 12'(Y_LIMIT);
                    end
                    if (kill_any) begin
                        alive_next     = alive_reg & ~(ONE_BIT << kill_idx);
                        hit_pulse_next = 1'b1;
                        hit_idx_next   = kill_idx;
                        score_next     = (score_reg >= SCORE_SAT_AT) ? SCORE_MAX
                                                                     : score_reg + 14'(POINTS);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A kill that empties the row wins over a simultaneous landing.
    always_comb begin
        state_next = state_reg;
        if (!play) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  state_next = S_MARCH;
                S_MARCH: begin
                    if (alive_next == '0) state_next = S_CLEARED;
                    else if (land_now)    state_next = S_LANDED;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state   = state_reg;
        cleared = (state_reg == S_CLEARED);
        landed  = (state_reg == S_LANDED);
    end

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            x_reg         <= 10'(X_START);
            y_reg         <= 10'(Y_START);
            alive_reg     <= ALL_ALIVE;
            dir_reg       <= 1'b1;
            div_reg       <= '0;
            score_reg     <= '0;
            hit_pulse_reg <= 1'b0;
            hit_idx_reg   <= '0;
        end else begin
            x_reg         <= x_next;
            y_reg         <= y_next;
            alive_reg     <= alive_next;
            dir_reg       <= dir_next;
            div_reg       <= div_next;
            score_reg     <= score_next;
            hit_pulse_reg <= hit_pulse_next;
            hit_idx_reg   <= hit_idx_next;
        end
    end

    assign enemy_x      = x_reg;
    assign enemy_y      = y_reg;
    assign alive        = alive_reg;
    assign hit_pulse    = hit_pulse_reg;
    assign proj_consume = hit_pulse_reg;
    assign hit_idx      = hit_idx_reg;
    assign score        = score_reg;

endmodule

// File: tb/tb_invader_formation.sv
// Scoreboard bench: stimulus runs an integer model of the formation rules and
// queues per-cycle expectations; a negedge monitor compares them with the DUT.
module tb_invader_formation;

    localparam int N   = 5;
    localparam int SP  = 40;
    localparam int HW  = 10;
    localparam int HT  = 20;
    localparam int PH  = 5;
    localparam int XMN = 96;
    localparam int XMX = 389;
    localparam int XS  = 100;
    localparam int YS  = 10;
    localparam int DR  = 5;
    localparam int YL  = 400;
    localparam int PTS = 50;
    localparam int BP  = 2;

    logic       dclk, clr, tick, play, proj_valid;
    logic [9:0] proj_x, proj_y;
    logic [9:0] enemy_x, enemy_y;
    logic [N-1:0] alive;
    logic       hit_pulse, proj_consume, cleared, landed;
    logic [3:0] hit_idx;
    logic [13:0] score;
    logic [1:0] state;

    logic       play2, pv2;
    logic [9:0] px2, py2;
    logic [9:0] ex2, ey2;
    logic [N-1:0] alive2;
    logic       hp2, pc2, cl2, ld2;
    logic [3:0] hi2;
    logic [13:0] sc2;
    logic [1:0] st2;
    logic       tick2;

    invader_formation u_dut (
        .dclk(dclk), .clr(clr), .tick(tick), .play(play),
        .proj_valid(proj_valid), .proj_x(proj_x), .proj_y(proj_y),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .alive(alive),
        .hit_pulse(hit_pulse), .hit_idx(hit_idx), .proj_consume(proj_consume),
        .score(score), .cleared(cleared), .landed(landed), .state(state)
    );

    invader_formation #(.SPACING(20)) u_dut_narrow (
        .dclk(dclk), .clr(clr), .tick(tick2), .play(play2),
        .proj_valid(pv2), .proj_x(px2), .proj_y(py2),
        .enemy_x(ex2), .enemy_y(ey2), .alive(alive2),
        .hit_pulse(hp2), .hit_idx(hi2), .proj_consume(pc2),
        .score(sc2), .cleared(cl2), .landed(ld2), .state(st2)
    );

    initial begin
        dclk = 1'b0;
        forever #5 dclk = ~dclk;
    end

    typedef struct {
        int x; int y; int alv; int hit; int idx; int score; int st;
    } snap_t;

    snap_t exp_q[$];
    int    hit_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    // Reference model state
    int m_state, mx, my, mdir, mdiv, m_score, m_hit, m_idx;
    bit m_alive[N];

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int alive_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_alive[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int live_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_alive[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        m_state = 0; mx = XS; my = YS; mdir = 1; mdiv = 0;
        m_score = 0; m_hit = 0; m_idx = 0;
        for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
    endtask

    task automatic model_step(input bit p, input bit t, input bit pv, input int px, input int py);
        int  kill, per, lo, hi, d;
        bit  land;
        m_hit = 0;
        if (!p) begin
            m_state = 0; mx = XS; my = YS; mdir = 1; mdiv = 0;
            for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
            return;
        end
        if (m_state == 0) begin
            m_state = 1; m_score = 0;
            for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
        end else if (m_state == 1) begin
            kill = -1;
            if (pv) begin
                for (int i = 0; i < N; i++) begin
                    d = px - (mx + i * SP);
                    if (d < 0) d = -d;
                    if (kill < 0 && m_alive[i] && py > my && py - my < HT && d < HW + PH) kill = i;
                end
            end
            lo = N; hi = -1;
            for (int i = 0; i < N; i++) if (m_alive[i]) begin
                if (lo == N) lo = i;
                hi = i;
            end
            land = 0;
            if (t) begin
                per = (live_count() > N / 2) ? BP : ((BP / 2 > 1) ? BP / 2 : 1);
                if (mdiv >= per - 1) begin
                    mdiv = 0;
                    if (mdir == 1 && mx + hi * SP + HW + 1 <= XMX)      mx = mx + 1;
                    else if (mdir == 0 && mx + lo * SP - HW - 1 >= XMN) mx = mx - 1;
                    else begin
                        my   = my + DR;
                        mdir = 1 - mdir;
                        land = (my + HT >= YL);
                    end
                end else begin
                    mdiv++;
                end
            end
            if (kill >= 0) begin
                m_alive[kill] = 1'b0;
                m_hit = 1; m_idx = kill;
                m_score = (m_score + PTS > 9999) ? 9999 : m_score + PTS;
                hit_q.push_back(kill);
            end
            if (live_count() == 0) m_state = 2;
            else if (land)         m_state = 3;
        end
    endtask

    task automatic cycle(input bit p, input bit t, input bit pv, input int px, input int py);
        snap_t s;
        int cpx, cpy;
        cpx = (px < 0) ? 0 : ((px > 1023) ? 1023 : px);
        cpy = (py < 0) ? 0 : ((py > 1023) ? 1023 : py);
        play = p; tick = t; proj_valid = pv;
        proj_x = 10'(cpx); proj_y = 10'(cpy);
        @(posedge dclk); #1;
        model_step(p, t, pv, cpx, cpy);
        s.x = mx; s.y = my; s.alv = alive_vec(); s.hit = m_hit; s.idx = m_idx;
        s.score = m_score; s.st = m_state;
        exp_q.push_back(s);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"},       int'(enemy_x), XS);
        chk({tag, "_y"},       int'(enemy_y), YS);
        chk({tag, "_alive"},   int'(alive), (1 << N) - 1);
        chk({tag, "_hit"},     int'(hit_pulse), 0);
        chk({tag, "_consume"}, int'(proj_consume), 0);
        chk({tag, "_idx"},     int'(hit_idx), 0);
        chk({tag, "_score"},   int'(score), 0);
        chk({tag, "_cleared"}, int'(cleared), 0);
        chk({tag, "_landed"},  int'(landed), 0);
        chk({tag, "_state"},   int'(state), 0);
    endtask

    task automatic async_reset();
        @(negedge dclk); #2;
        clr = 1'b0;
        #1;
        check_reset("async");
        @(posedge dclk); #1;
        clr = 1'b1;
        model_reset();
    endtask

    // Monitor: one expectation per cycle, plus kill records on hit_pulse
    initial begin
        snap_t e;
        int h;
        forever begin
            @(negedge dclk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (int'(enemy_x) != e.x || int'(enemy_y) != e.y || int'(alive) != e.alv ||
                    int'(hit_pulse) != e.hit || int'(proj_consume) != e.hit ||
                    (e.hit == 1 && int'(hit_idx) != e.idx) || int'(score) != e.score ||
                    int'(state) != e.st || int'(cleared) != int'(e.st == 2) ||
                    int'(landed) != int'(e.st == 3)) begin
                    n_fail++;
                    $display("FAIL cycle %0d: got x=%0d y=%0d alive=%h hit=%0d cons=%0d idx=%0d score=%0d st=%0d, expected x=%0d y=%0d alive=%h hit=%0d idx=%0d score=%0d st=%0d",
                             cyc, enemy_x, enemy_y, alive, hit_pulse, proj_consume, hit_idx, score, state,
                             e.x, e.y, e.alv, e.hit, e.idx, e.score, e.st);
                end
                if (hit_pulse) begin
                    if (hit_q.size() == 0) begin
                        chk("unexpected_kill", 1, 0);
                    end else begin
                        h = hit_q.pop_front();
                        chk("kill_idx", int'(hit_idx), h);
                        $display("[TB] kill idx=%0d score=%0d", hit_idx, score);
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit cpv;
        int cpx, cpy, col;
        clr = 1'b0; play = 1'b0; tick = 1'b0; proj_valid = 1'b0; proj_x = '0; proj_y = '0;
        play2 = 1'b0; pv2 = 1'b0; px2 = '0; py2 = '0; tick2 = 1'b0;
        repeat (2) @(posedge dclk);
        #1;
        check_reset("por");
        clr = 1'b1;
        model_reset();

        // March with no projectile through the first reversal
        cycle(1, 0, 0, 0, 0);
        repeat (600) cycle(1, 1, 0, 0, 0);

        // Directed hit on column 1 at the start position, then hold the shot
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 140, 15);
        cycle(1, 0, 1, 140, 15);
        cycle(1, 0, 1, 140, 15);

        // Kill the outer right columns; period halves and the right edge widens
        cycle(1, 0, 1, mx + 3 * SP, my + 5);
        cycle(1, 0, 1, mx + 4 * SP, my + 5);
        repeat (500) cycle(1, 1, 0, 0, 0);

        // Finish the row while stepping, then check the frozen terminal state
        for (int i = 0; i < N; i++)
            if (m_alive[i]) cycle(1, 1, 1, mx + i * SP, my + 5);
        repeat (10) cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);

        // Randomised play with held/aimed projectiles and occasional restarts
        cpv = 0; cpx = 0; cpy = 0;
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                col = $urandom_range(0, N - 1);
                cpv = ($urandom_range(0, 1) == 1);
                cpx = mx + col * SP + $urandom_range(0, 40) - 20;
                cpy = my + $urandom_range(0, 26) - 3;
            end
            if ($urandom_range(0, 999) == 0) async_reset();
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, cpv, cpx, cpy);
        end

        // Let a full row march down to the landing line
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 40000 && m_state != 3; k++) cycle(1, 1, 0, 0, 0);
        @(negedge dclk); #1;
        chk("landed_reached", int'(landed), 1);
        for (int k = 0; k < 10; k++) cycle(1, 1, 1, mx + (k % N) * SP, my + 5);

        // Reset asserted while a step is pending
        cycle(1, 1, 0, 0, 0);
        async_reset();

        // Narrow spacing: a shot covering columns 0 and 1 kills only column 0
        @(posedge dclk); #1;
        play2 = 1'b1;
        @(posedge dclk); #1;
        pv2 = 1'b1; px2 = 10'd110; py2 = 10'd15;
        @(posedge dclk); #1;
        pv2 = 1'b0;
        chk("narrow_hit", int'(hp2), 1);
        chk("narrow_idx", int'(hi2), 0);
        chk("narrow_alive", int'(alive2), 5'b11110);
        @(posedge dclk); #1;
        chk("narrow_strobe_end", int'(hp2), 0);

        repeat (3) @(negedge dclk);
        #1;
        chk("pending_kills", hit_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
